wb_stage: RTL and testbench

- Writeback stage; consumes the MEM/WB pipeline register outputs (wr_*) each cycle.
- Produces the GPR write port with load alignment and extension.
- Owns architectural HI/LO and the CP0 bank (Status, Cause, EPC, Count, Compare), including exception entry and ERET redirect.
- Register state only; the GPR array lives in the register-file block.

---
 rtl/wb_pkg.sv | 50 +++++
 rtl/wb_cp0_regs.sv | 106 ++++++++++
 rtl/wb_stage.sv | 85 ++++++++
 tb/tb_wb_stage.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared writeback-stage definitions: CP0 op codes, CP0 register numbers,
// exception codes, result-source selects, load opcodes and the load aligner.
package wb_pkg;

    typedef enum logic [2:0] {
        CP0_NONE    = 3'd0,
        CP0_MFC0    = 3'd1,
        CP0_MTC0    = 3'd2,
        CP0_ERET    = 3'd3,
        CP0_SYSCALL = 3'd4,
        CP0_BREAK   = 3'd5
    } cp0_op_e;

    localparam logic [4:0] CP0_COUNT   = 5'd9;
    localparam logic [4:0] CP0_COMPARE = 5'd11;
    localparam logic [4:0] CP0_STATUS  = 5'd12;
    localparam logic [4:0] CP0_CAUSE   = 5'd13;
    localparam logic [4:0] CP0_EPC     = 5'd14;

    localparam logic [4:0] EXC_SYS = 5'd8;
    localparam logic [4:0] EXC_BP  = 5'd9;

    localparam logic [1:0] MTR_RESULT = 2'd0;
    localparam logic [1:0] MTR_LOAD   = 2'd1;
    localparam logic [1:0] MTR_HL     = 2'd2;
    localparam logic [1:0] MTR_CP0    = 2'd3;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;

    // Little-endian byte/halfword pick with sign or zero extension.
    function automatic logic [31:0] load_align(input logic [5:0] op,
                                               input logic [31:0] data,
                                               input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        b = data[{off, 3'b000} +: 8];
        h = off[1] ? data[31:16] : data[15:0];
        case (op)
            OP_LB:   return {{24{b[7]}}, b};
            OP_LBU:  return {24'h0, b};
            OP_LH:   return {{16{h[15]}}, h};
            OP_LHU:  return {16'h0, h};
            default: return data;
        endcase
    endfunction

endpackage

// File: rtl/wb_cp0_regs.sv
// CP0 bank (Status, Cause, EPC, optional Count/Compare timer) with exception
// entry, ERET and the one-cycle redirect pulse. Timer built only with CP0_TIMER_EN.
module wb_cp0_regs #(
    parameter logic [31:0] EXC_VECTOR = 32'h8000_0180,
    parameter int          COUNT_DIV  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  cp0op,
    input  logic [4:0]  cs,
    input  logic [2:0]  sel,
    input  logic [31:0] wdata,
    input  logic [31:0] pc,
    output logic [31:0] status,
    output logic [31:0] cause,
    output logic [31:0] epc,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        irq_pending
);
    import wb_pkg::*;

    logic [1:0] ip_sw;
    logic [4:0] exc_code;
    logic       ip7;
    logic       mtc0, exc;

    assign mtc0 = (cp0op == CP0_MTC0) && (sel == 3'd0);
    assign exc  = (cp0op == CP0_SYSCALL) || (cp0op == CP0_BREAK);

    assign cause = {16'h0, ip7, 5'h0, ip_sw, 1'b0, exc_code, 2'b00};
    assign irq_pending = status[0] & status[15] & ~status[1] & ip7;

    always_ff @(posedge clk) begin
        if (rst) begin
            status      <= '0;
            ip_sw       <= '0;
            exc_code    <= '0;
            epc         <= '0;
            redirect    <= 1'b0;
            redirect_pc <= '0;
        end else begin
            redirect <= 1'b0;
            if (mtc0) begin
                case (cs)
                    CP0_STATUS: status <= wdata;
                    CP0_CAUSE:  ip_sw  <= wdata[9:8];
                    CP0_EPC:    epc    <= wdata;
                    default: ;
                endcase
            end
            if (exc) begin
                // A nested exception keeps the original return address.
                if (!status[1]) epc <= pc;
                status[1]   <= 1'b1;
                exc_code    <= (cp0op == CP0_SYSCALL) ? EXC_SYS : EXC_BP;
                redirect    <= 1'b1;
                redirect_pc <= EXC_VECTOR;
            end
            if (cp0op == CP0_ERET) begin
                status[1]   <= 1'b0;
                redirect    <= 1'b1;
                redirect_pc <= epc;
            end
        end
    end

`ifdef CP0_TIMER_EN
    localparam int DIV_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

    logic [DIV_W-1:0] div;
    logic [31:0]      count, compare, count_nxt, compare_nxt;
    logic             tick, count_wr, compare_wr, match;

    assign tick       = (div == DIV_W'(COUNT_DIV - 1));
    assign count_wr   = mtc0 && (cs == CP0_COUNT);
    assign compare_wr = mtc0 && (cs == CP0_COMPARE);

    always_comb begin
        count_nxt = count;
        if (tick)     count_nxt = count + 32'd1;
        if (count_wr) count_nxt = wdata;
        compare_nxt = compare_wr ? wdata : compare;
        match       = (tick || count_wr) && (count_nxt == compare_nxt);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div     <= '0;
            count   <= '0;
            compare <= '0;
            ip7     <= 1'b0;
        end else begin
            div     <= tick ? '0 : div + 1'b1;
            count   <= count_nxt;
            compare <= compare_nxt;
            // Compare write acknowledges the interrupt even against a fresh match.
            if (compare_wr)  ip7 <= 1'b0;
            else if (match)  ip7 <= 1'b1;
        end
    end
`else
    assign ip7 = 1'b0;
`endif

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: GPR write port with load alignment, HI/LO, and the CP0 bank.
// Define CP0_TIMER_EN to build the Count/Compare timer.
module wb_stage #(
    parameter logic [31:0] EXC_VECTOR = 32'h8000_0180,
    parameter int          COUNT_DIV  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] wr_dout,
    input  logic [31:0] wr_result,
    input  logic [31:0] wr_HL,
    input  logic [31:0] wr_busA_mux2,
    input  logic [31:0] wr_busB_mux2,
    input  logic [31:0] wr_cp0_dout,
    input  logic [31:0] wr_pc,
    input  logic [63:0] wr_mult,
    input  logic [4:0]  wr_rw,
    input  logic [4:0]  wr_cs,
    input  logic [2:0]  wr_sel,
    input  logic [2:0]  wr_cp0op,
    input  logic        wr_regWr,
    input  logic        wr_multWr,
    input  logic        wr_Lowin,
    input  logic        wr_Highin,
    input  logic [1:0]  wr_memtoreg,
    input  logic [5:0]  wr_op,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] cp0_status,
    output logic [31:0] cp0_cause,
    output logic [31:0] cp0_epc,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        irq_pending
);
    import wb_pkg::*;

    assign rf_waddr = wr_rw;
    assign rf_we    = wr_regWr & (wr_rw != 5'd0);

    always_comb begin
        rf_wdata = wr_result;
        case (wr_memtoreg)
            MTR_LOAD: rf_wdata = load_align(wr_op, wr_dout, wr_result[1:0]);
            MTR_HL:   rf_wdata = wr_HL;
            MTR_CP0:  rf_wdata = wr_cp0_dout;
            default:  rf_wdata = wr_result;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi <= '0;
            lo <= '0;
        end else if (wr_multWr) begin
            {hi, lo} <= wr_mult;
        end else begin
            if (wr_Lowin)  lo <= wr_busA_mux2;
            if (wr_Highin) hi <= wr_busA_mux2;
        end
    end

    wb_cp0_regs #(
        .EXC_VECTOR (EXC_VECTOR),
        .COUNT_DIV  (COUNT_DIV)
    ) u_cp0 (
        .clk         (clk),
        .rst         (rst),
        .cp0op       (wr_cp0op),
        .cs          (wr_cs),
        .sel         (wr_sel),
        .wdata       (wr_busB_mux2),
        .pc          (wr_pc),
        .status      (cp0_status),
        .cause       (cp0_cause),
        .epc         (cp0_epc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .irq_pending (irq_pending)
    );

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: loads, GPR enable, HI/LO, exceptions/ERET,
// timer interrupt (or its absence without CP0_TIMER_EN), and reset override.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] wr_dout, wr_result, wr_HL, wr_busA_mux2, wr_busB_mux2, wr_cp0_dout, wr_pc;
    logic [63:0] wr_mult;
    logic [4:0]  wr_rw, wr_cs;
    logic [2:0]  wr_sel, wr_cp0op;
    logic        wr_regWr, wr_multWr, wr_Lowin, wr_Highin;
    logic [1:0]  wr_memtoreg;
    logic [5:0]  wr_op;
    logic        rf_we, redirect, irq_pending;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata, hi, lo, cp0_status, cp0_cause, cp0_epc, redirect_pc;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wb_stage #(.EXC_VECTOR(32'h8000_0180), .COUNT_DIV(2)) dut (
        .clk(clk), .rst(rst),
        .wr_dout(wr_dout), .wr_result(wr_result), .wr_HL(wr_HL),
        .wr_busA_mux2(wr_busA_mux2), .wr_busB_mux2(wr_busB_mux2),
        .wr_cp0_dout(wr_cp0_dout), .wr_pc(wr_pc), .wr_mult(wr_mult),
        .wr_rw(wr_rw), .wr_cs(wr_cs), .wr_sel(wr_sel), .wr_cp0op(wr_cp0op),
        .wr_regWr(wr_regWr), .wr_multWr(wr_multWr), .wr_Lowin(wr_Lowin),
        .wr_Highin(wr_Highin), .wr_memtoreg(wr_memtoreg), .wr_op(wr_op),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .hi(hi), .lo(lo), .cp0_status(cp0_status), .cp0_cause(cp0_cause),
        .cp0_epc(cp0_epc), .redirect(redirect), .redirect_pc(redirect_pc),
        .irq_pending(irq_pending)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic idle();
        wr_dout = '0; wr_result = '0; wr_HL = '0; wr_busA_mux2 = '0;
        wr_busB_mux2 = '0; wr_cp0_dout = '0; wr_pc = '0; wr_mult = '0;
        wr_rw = '0; wr_cs = '0; wr_sel = '0; wr_cp0op = 3'd0;
        wr_regWr = 0; wr_multWr = 0; wr_Lowin = 0; wr_Highin = 0;
        wr_memtoreg = '0; wr_op = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mtc0(input logic [4:0] cs, input logic [31:0] d);
        wr_cp0op = 3'd2; wr_cs = cs; wr_sel = 3'd0; wr_busB_mux2 = d;
        step();
        idle();
    endtask

    initial begin
        idle();
        rst = 1'b1;
        step();
        step();
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        chk("rst_status", cp0_status, 32'h0);
        chk("rst_cause", cp0_cause, 32'h0);
        chk("rst_epc", cp0_epc, 32'h0);
        chk("rst_redirect", {31'h0, redirect}, 32'h0);
        chk("rst_redirect_pc", redirect_pc, 32'h0);
        rst = 1'b0;

        // Loads from 80FF_7F01
        wr_memtoreg = 2'd1; wr_dout = 32'h80FF_7F01;
        wr_op = 6'h20; wr_result = 32'h1001; #1;
        chk("lb_off1", rf_wdata, 32'h0000_007F);
        wr_result = 32'h1003; #1;
        chk("lb_off3", rf_wdata, 32'hFFFF_FF80);
        wr_op = 6'h25; wr_result = 32'h1002; #1;
        chk("lhu_off2", rf_wdata, 32'h0000_80FF);
        wr_op = 6'h21; #1;
        chk("lh_off2", rf_wdata, 32'hFFFF_80FF);
        wr_op = 6'h24; wr_result = 32'h1003; #1;
        chk("lbu_off3", rf_wdata, 32'h0000_0080);
        wr_op = 6'h23; #1;
        chk("lw_passthru", rf_wdata, 32'h80FF_7F01);
        wr_memtoreg = 2'd2; wr_HL = 32'hABCD_0001; #1;
        chk("mtr_hl", rf_wdata, 32'hABCD_0001);
        wr_memtoreg = 2'd3; wr_cp0_dout = 32'h1234_5678; #1;
        chk("mtr_cp0", rf_wdata, 32'h1234_5678);
        wr_memtoreg = 2'd0; #1;
        chk("mtr_result", rf_wdata, 32'h0000_1003);

        wr_regWr = 1; wr_rw = 5'd0; #1;
        chk("we_r0", {31'h0, rf_we}, 32'h0);
        wr_rw = 5'd5; #1;
        chk("we_r5", {31'h0, rf_we}, 32'h1);
        chk("waddr_r5", {27'h0, rf_waddr}, 32'd5);
        idle();

        // HI/LO
        wr_multWr = 1; wr_Lowin = 1; wr_busA_mux2 = 32'h55; wr_mult = 64'h1_0000_0002;
        step();
        chk("mult_hi", hi, 32'h1);
        chk("mult_lo", lo, 32'h2);
        idle();
        wr_Highin = 1; wr_busA_mux2 = 32'h7;
        step();
        chk("mthi_hi", hi, 32'h7);
        chk("mthi_lo", lo, 32'h2);
        idle();
        wr_Highin = 1; wr_Lowin = 1; wr_busA_mux2 = 32'h9;
        step();
        chk("both_hi", hi, 32'h9);
        chk("both_lo", lo, 32'h9);
        idle();

        // SYSCALL then ERET
        wr_cp0op = 3'd4; wr_pc = 32'h400;
        step();
        idle();
        chk("sys_epc", cp0_epc, 32'h400);
        chk("sys_exl", {31'h0, cp0_status[1]}, 32'h1);
        chk("sys_code", {27'h0, cp0_cause[6:2]}, 32'd8);
        chk("sys_redirect", {31'h0, redirect}, 32'h1);
        chk("sys_redirect_pc", redirect_pc, 32'h8000_0180);
        step();
        chk("sys_pulse_end", {31'h0, redirect}, 32'h0);
        wr_cp0op = 3'd3;
        step();
        idle();
        chk("eret_exl", {31'h0, cp0_status[1]}, 32'h0);
        chk("eret_redirect", {31'h0, redirect}, 32'h1);
        chk("eret_redirect_pc", redirect_pc, 32'h400);
        step();
        chk("eret_pulse_end", {31'h0, redirect}, 32'h0);

        // Back-to-back BREAKs: second one must not overwrite EPC
        wr_cp0op = 3'd5; wr_pc = 32'h500;
        step();
        chk("brk1_epc", cp0_epc, 32'h500);
        chk("brk1_code", {27'h0, cp0_cause[6:2]}, 32'd9);
        wr_pc = 32'h600;
        step();
        idle();
        chk("brk2_epc_kept", cp0_epc, 32'h500);
        chk("brk2_redirect", {31'h0, redirect}, 32'h1);
        wr_cp0op = 3'd3;
        step();
        idle();
        chk("eret2_redirect_pc", redirect_pc, 32'h500);

        // MTC0 Cause masks to [9:8]; sel!=0 is ignored
        mtc0(5'd13, 32'hFFFF_FFFF);
        chk("cause_mask", cp0_cause, 32'h0000_0324);
        wr_cp0op = 3'd2; wr_cs = 5'd14; wr_sel = 3'd1; wr_busB_mux2 = 32'hDEAD_BEEF;
        step();
        idle();
        chk("mtc0_sel1_ignored", cp0_epc, 32'h500);
        mtc0(5'd14, 32'h0000_0ABC);
        chk("mtc0_epc", cp0_epc, 32'h0000_0ABC);

        // Timer interrupt
        mtc0(5'd12, 32'h0000_8001);
        chk("mtc0_status", cp0_status, 32'h0000_8001);
        mtc0(5'd11, 32'd3);
        mtc0(5'd9, 32'd0);
`ifdef CP0_TIMER_EN
        chk("ip7_before", {31'h0, cp0_cause[15]}, 32'h0);
        for (int n = 0; n < 40 && !cp0_cause[15]; n++) step();
        chk("ip7_set", {31'h0, cp0_cause[15]}, 32'h1);
        chk("irq_set", {31'h0, irq_pending}, 32'h1);
        step();
        chk("ip7_sticky", {31'h0, cp0_cause[15]}, 32'h1);
        mtc0(5'd11, 32'd100);
        chk("ip7_clear", {31'h0, cp0_cause[15]}, 32'h0);
        chk("irq_clear", {31'h0, irq_pending}, 32'h0);
`else
        for (int n = 0; n < 12; n++) step();
        chk("ip7_absent", {31'h0, cp0_cause[15]}, 32'h0);
        chk("irq_absent", {31'h0, irq_pending}, 32'h0);
`endif

        // Reset right after SYSCALL overrides the pending pulse
        wr_cp0op = 3'd4; wr_pc = 32'h700;
        step();
        idle();
        chk("sys3_redirect", {31'h0, redirect}, 32'h1);
        rst = 1'b1;
        step();
        chk("rst2_redirect", {31'h0, redirect}, 32'h0);
        chk("rst2_status", cp0_status, 32'h0);
        chk("rst2_cause", cp0_cause, 32'h0);
        chk("rst2_epc", cp0_epc, 32'h0);
        chk("rst2_hi", hi, 32'h0);
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
